// File: rtl/pc_decision_unit_pkg.sv
// Shared definitions for the PC decision unit: PC-mux selects, branch
// condition codes, FSM state encoding and the captured-redirect record.
package pc_decision_unit_pkg;

    localparam logic [2:0] PC_SEL_ADDER  = 3'b000;
    localparam logic [2:0] PC_SEL_EX_TA  = 3'b001;
    localparam logic [2:0] PC_SEL_ID_TA  = 3'b010;
    localparam logic [2:0] PC_SEL_EX_ALU = 3'b011;

    localparam logic [3:0] COND_NEVER  = 4'b0000;
    localparam logic [3:0] COND_ALWAYS = 4'b0001;
    localparam logic [3:0] COND_EQ     = 4'b0010;
    localparam logic [3:0] COND_NE     = 4'b0011;
    localparam logic [3:0] COND_LT     = 4'b0100;
    localparam logic [3:0] COND_GE     = 4'b0101;
    localparam logic [3:0] COND_GT     = 4'b0110;
    localparam logic [3:0] COND_LE     = 4'b0111;
    localparam logic [3:0] COND_CS     = 4'b1000;
    localparam logic [3:0] COND_CC     = 4'b1001;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pcd_state_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       flush_ifid;
        logic       flush_idex;
    } redirect_t;

endpackage

// File: rtl/pc_decision_unit_branch_cond_eval.sv
// Combinational branch condition evaluator: condition code + {N,Z,C,V} -> taken.
// Undefined condition codes evaluate as not taken.
module branch_cond_eval
    import pc_decision_unit_pkg::*;
(
    input  logic [3:0] ex_cond,
    input  logic [3:0] ex_flags,
    output logic       taken
);

    logic n_f, z_f, c_f, v_f;
    logic lt;

    assign n_f = ex_flags[3];
    assign z_f = ex_flags[2];
    assign c_f = ex_flags[1];
    assign v_f = ex_flags[0];
    assign lt  = n_f ^ v_f;

    always_comb begin
        taken = 1'b0;
        case (ex_cond)
            COND_NEVER:  taken = 1'b0;
            COND_ALWAYS: taken = 1'b1;
            COND_EQ:     taken = z_f;
            COND_NE:     taken = !z_f;
            COND_LT:     taken = lt;
            COND_GE:     taken = !lt;
            COND_GT:     taken = !z_f && !lt;
            COND_LE:     taken = z_f || lt;
            COND_CS:     taken = c_f;
            COND_CC:     taken = !c_f;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_decision_unit.sv
// PC-source select and flush generation for the IF-stage PC mux, with
// freeze-time redirect capture/replay and saturating branch statistics.
module pc_decision_unit
    import pc_decision_unit_pkg::*;
#(
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             ex_branch,
    input  logic [3:0]       ex_cond,
    input  logic [3:0]       ex_flags,
    input  logic             ex_jr,
    input  logic             id_jump,
    output logic [2:0]       decision_output,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             pending,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    logic       cond_true;
    logic       branch_taken;
    logic       redirect_any;
    logic       capture;
    logic       accept;
    redirect_t  live_rd;
    redirect_t  held_q;
    redirect_t  out_rd;
    pcd_state_t state_q;
    pcd_state_t state_d;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] taken_q;

    branch_cond_eval u_cond (
        .ex_cond  (ex_cond),
        .ex_flags (ex_flags),
        .taken    (cond_true)
    );

    assign branch_taken = ex_branch && cond_true;

    // EX outranks ID (ID is younger); a taken branch outranks ex_jr.
    always_comb begin
        live_rd = '0;
        if (branch_taken) begin
            live_rd.sel        = PC_SEL_EX_TA;
            live_rd.flush_ifid = 1'b1;
            live_rd.flush_idex = !DELAY_SLOT;
        end else if (ex_jr) begin
            live_rd.sel        = PC_SEL_EX_ALU;
            live_rd.flush_ifid = 1'b1;
            live_rd.flush_idex = !DELAY_SLOT;
        end else if (id_jump) begin
            live_rd.sel        = PC_SEL_ID_TA;
            live_rd.flush_ifid = !DELAY_SLOT;
            live_rd.flush_idex = 1'b0;
        end
    end

    assign redirect_any = (live_rd.sel != PC_SEL_ADDER);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_RUN: begin
                accept = ex_branch && (!freeze || redirect_any);
                if (freeze && redirect_any) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!freeze) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Nothing reaches the PC mux while frozen; the held redirect is replayed
    // in the first unfrozen cycle and live inputs are ignored then.
    always_comb begin
        out_rd = '0;
        if (!freeze) begin
            if (state_q == ST_HOLD) out_rd = held_q;
            else                    out_rd = live_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            held_q  <= '0;
            total_q <= '0;
            taken_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) held_q <= live_rd;
            if (accept && (total_q != '1)) total_q <= total_q + CNT_W'(1);
            if (accept && branch_taken && (taken_q != '1)) taken_q <= taken_q + CNT_W'(1);
        end
    end

    assign decision_output = out_rd.sel;
    assign flush_ifid      = out_rd.flush_ifid;
    assign flush_idex      = out_rd.flush_idex;
    assign pending         = (state_q == ST_HOLD);
    assign br_total        = total_q;
    assign br_taken        = taken_q;

endmodule

// File: tb/tb_pc_decision_unit.sv
// Directed bench for pc_decision_unit: one instance with a delay slot and
// 16-bit counters, one without a delay slot and 4-bit (saturating) counters.
module tb_pc_decision_unit;

    logic       clk = 1'b0;
    logic       reset, freeze, ex_branch, ex_jr, id_jump;
    logic [3:0] ex_cond, ex_flags;

    logic [2:0]  dec1, dec0;
    logic        ifid1, idex1, pend1, ifid0, idex0, pend0;
    logic [15:0] tot1, tkn1;
    logic [3:0]  tot0, tkn0;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_total = 0;
    int exp_taken = 0;

    always #5 clk = ~clk;

    pc_decision_unit #(.DELAY_SLOT(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .freeze(freeze), .ex_branch(ex_branch),
        .ex_cond(ex_cond), .ex_flags(ex_flags), .ex_jr(ex_jr), .id_jump(id_jump),
        .decision_output(dec1), .flush_ifid(ifid1), .flush_idex(idex1),
        .pending(pend1), .br_total(tot1), .br_taken(tkn1)
    );

    pc_decision_unit #(.DELAY_SLOT(1'b0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .freeze(freeze), .ex_branch(ex_branch),
        .ex_cond(ex_cond), .ex_flags(ex_flags), .ex_jr(ex_jr), .id_jump(id_jump),
        .decision_output(dec0), .flush_ifid(ifid0), .flush_idex(idex0),
        .pending(pend0), .br_total(tot0), .br_taken(tkn0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int sat4(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, " tot1"}, 32'(tot1), 32'(exp_total));
        check({tag, " tkn1"}, 32'(tkn1), 32'(exp_taken));
        check({tag, " tot0"}, 32'(tot0), 32'(sat4(exp_total)));
        check({tag, " tkn0"}, 32'(tkn0), 32'(sat4(exp_taken)));
    endtask

    task automatic idle_inputs();
        freeze = 0; ex_branch = 0; ex_jr = 0; id_jump = 0;
        ex_cond = 4'b0000; ex_flags = 4'b0000;
    endtask

    // One unfrozen branch cycle: check the select, then the counters after the edge.
    task automatic branch_vec(input string tag, input logic [3:0] c, input logic [3:0] f, input bit tk);
        idle_inputs();
        ex_branch = 1; ex_cond = c; ex_flags = f;
        #1;
        check({tag, " dec1"}, 32'(dec1), tk ? 32'h1 : 32'h0);
        check({tag, " dec0"}, 32'(dec0), tk ? 32'h1 : 32'h0);
        exp_total++;
        if (tk) exp_taken++;
        @(negedge clk);
    endtask

    typedef struct { logic [3:0] c; logic [3:0] f; bit tk; } cvec_t;
    cvec_t cvecs[10];

    initial begin
        cvecs[0] = '{4'b0000, 4'b0000, 1'b0};
        cvecs[1] = '{4'b0001, 4'b0000, 1'b1};
        cvecs[2] = '{4'b0011, 4'b0100, 1'b0};
        cvecs[3] = '{4'b0101, 4'b1000, 1'b0};
        cvecs[4] = '{4'b0110, 4'b0000, 1'b1};
        cvecs[5] = '{4'b0111, 4'b0001, 1'b1};
        cvecs[6] = '{4'b1000, 4'b0010, 1'b1};
        cvecs[7] = '{4'b1001, 4'b0010, 1'b0};
        cvecs[8] = '{4'b1010, 4'b1111, 1'b0};
        cvecs[9] = '{4'b1111, 4'b1111, 1'b0};

        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        check("rst dec1", 32'(dec1), 32'h0);
        check("rst flush1", 32'({ifid1, idex1}), 32'h0);
        check("rst pend1", 32'(pend1), 32'h0);
        check_counters("rst");
        reset = 0;

        // Taken BEQ with Z=1
        ex_branch = 1; ex_cond = 4'b0010; ex_flags = 4'b0100;
        #1;
        check("beq dec1", 32'(dec1), 32'h1);
        check("beq ifid1", 32'(ifid1), 32'h1);
        check("beq idex1", 32'(idex1), 32'h0);
        check("beq ifid0", 32'(ifid0), 32'h1);
        check("beq idex0", 32'(idex0), 32'h1);
        exp_total = 1; exp_taken = 1;
        @(negedge clk);
        check_counters("beq");

        // Not-taken LT (N=V=1) alongside an ID jump
        ex_branch = 1; ex_cond = 4'b0100; ex_flags = 4'b1001; id_jump = 1;
        #1;
        check("lt+j dec1", 32'(dec1), 32'h2);
        check("lt+j ifid1", 32'(ifid1), 32'h0);
        check("lt+j ifid0", 32'(ifid0), 32'h1);
        check("lt+j idex0", 32'(idex0), 32'h0);
        exp_total++;
        @(negedge clk);
        check_counters("lt+j");

        // JR and ID jump together
        idle_inputs();
        ex_jr = 1; id_jump = 1;
        #1;
        check("jr dec0", 32'(dec0), 32'h3);
        check("jr flush0", 32'({ifid0, idex0}), 32'h3);
        check("jr flush1", 32'({ifid1, idex1}), 32'h2);
        @(negedge clk);

        // Taken branch with ex_jr: branch wins
        idle_inputs();
        ex_branch = 1; ex_cond = 4'b0001; ex_jr = 1;
        #1;
        check("br>jr dec1", 32'(dec1), 32'h1);
        exp_total++; exp_taken++;
        @(negedge clk);

        foreach (cvecs[i]) branch_vec($sformatf("cond%0d", i), cvecs[i].c, cvecs[i].f, cvecs[i].tk);
        check_counters("conds");

        // Freeze with JR: capture, 3 HOLD cycles ignoring a new ID jump, replay
        idle_inputs();
        freeze = 1; ex_jr = 1;
        #1;
        check("cap dec1", 32'(dec1), 32'h0);
        check("cap flush1", 32'({ifid1, idex1}), 32'h0);
        check("cap pend1", 32'(pend1), 32'h0);
        @(negedge clk);
        ex_jr = 0; id_jump = 1;
        for (int unsigned k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d pend1", k), 32'(pend1), 32'h1);
            check($sformatf("hold%0d dec1", k), 32'(dec1), 32'h0);
            check($sformatf("hold%0d flush0", k), 32'({ifid0, idex0}), 32'h0);
            @(negedge clk);
        end
        freeze = 0;
        #1;
        check("replay dec1", 32'(dec1), 32'h3);
        check("replay flush1", 32'({ifid1, idex1}), 32'h2);
        check("replay flush0", 32'({ifid0, idex0}), 32'h3);
        check("replay pend1", 32'(pend1), 32'h1);
        @(negedge clk);
        id_jump = 0;
        #1;
        check("post dec1", 32'(dec1), 32'h0);
        check("post pend1", 32'(pend1), 32'h0);
        check("post flush1", 32'({ifid1, idex1}), 32'h0);
        @(negedge clk);

        // Frozen not-taken branch with no other redirect is not accepted
        idle_inputs();
        freeze = 1; ex_branch = 1; ex_cond = 4'b0000;
        @(negedge clk);
        check("frz nt pend1", 32'(pend1), 32'h0);
        check_counters("frz nt");

        // Frozen taken branch is counted once at capture, not at replay
        ex_cond = 4'b0001;
        exp_total++; exp_taken++;
        @(negedge clk);
        check_counters("frz cap");
        freeze = 0;
        #1;
        check("frz replay dec1", 32'(dec1), 32'h1);
        @(negedge clk);
        idle_inputs();
        check_counters("frz replay");

        // Saturation of the 4-bit counters
        for (int unsigned k = 0; k < 16; k++) begin
            ex_branch = 1; ex_cond = 4'b0001;
            exp_total++; exp_taken++;
            @(negedge clk);
        end
        idle_inputs();
        check_counters("sat");
        check("sat tot0 ones", 32'(tot0), 32'hF);
        check("sat tkn0 ones", 32'(tkn0), 32'hF);

        // Reset while holding discards the capture
        freeze = 1; ex_jr = 1;
        @(negedge clk);
        check("rh pend1", 32'(pend1), 32'h1);
        reset = 1;
        @(negedge clk);
        check("rh pend1 after", 32'(pend1), 32'h0);
        check("rh pend0 after", 32'(pend0), 32'h0);
        exp_total = 0; exp_taken = 0;
        check_counters("rh");
        reset = 0;
        idle_inputs();
        #1;
        check("rh dec1", 32'(dec1), 32'h0);
        check("rh flush1", 32'({ifid1, idex1}), 32'h0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_decision_unit.md
# pc_decision_unit

Generates the 3-bit PC-source select consumed by the IF-stage PC mux, plus the matching pipeline flush pulses. Evaluates EX-stage conditional branches against ALU flags, EX-stage jump-register, and ID-stage direct jumps. Captures a redirect that arrives while the pipeline is frozen and replays it when the freeze lifts. Keeps saturating branch statistics. Sits between the control unit / hazard unit and the IF-stage PC mux.

## Interface
- DELAY_SLOT, 1: 1 means the instruction after a control transfer executes (architectural delay slot); 0 means it is squashed.
- CNT_W, 16: width of the statistics counters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- freeze  in  1  whole-pipeline hold (memory wait); the PC does not load while high.
- ex_branch  in  1  EX holds a conditional branch.
- ex_cond  in  4  branch condition code from EX.
- ex_flags  in  4  {N,Z,C,V} from the EX ALU.
- ex_jr  in  1  EX holds a jump-register (target = ex_alu).
- id_jump  in  1  ID holds a direct jump (target = id_TA).
- decision_output  out  3  PC source select: 000 = adder_out (PC+4), 001 = ex_TA, 010 = id_TA, 011 = ex_alu; 1xx is never driven.
- flush_ifid  out  1  bubble the IF/ID register.
- flush_idex  out  1  bubble the ID/EX register.
- pending  out  1  a captured redirect is waiting for freeze to drop.
- br_total  out  CNT_W  number of conditional branches evaluated.
- br_taken  out  CNT_W  number of conditional branches taken.

## Operation
- Condition decode (ex_cond): 0000 = never, 0001 = always, 0010 = Z, 0011 = !Z, 0100 = N^V (lt), 0101 = !(N^V) (ge), 0110 = !Z & !(N^V) (gt), 0111 = Z | (N^V) (le), 1000 = C, 1001 = !C. Codes 1010–1111 evaluate as not taken.
- Priority, from highest:
  - EX taken branch -> 001.
  - ex_jr -> 011.
  - id_jump -> 010.
  - otherwise 000.
- EX redirect outranks ID: the ID instruction is younger. If ex_branch and ex_jr are both high, the branch wins.
- Flushes:
  - EX redirect: flush_ifid = 1; flush_idex = !DELAY_SLOT.
  - ID jump: flush_ifid = !DELAY_SLOT; flush_idex = 0.
  - No redirect: both 0.
- State machine RUN / HOLD:
  - RUN, freeze = 0: outputs are combinational from the current inputs; stay in RUN.
  - RUN, freeze = 1, redirect present: latch the select and both flush values; go to HOLD. decision_output = 000 and flushes = 0 this cycle.
  - RUN, freeze = 1, no redirect: outputs 000 / 0; stay in RUN.
  - HOLD, freeze = 1: outputs 000 / 0; all new inputs are ignored; stay in HOLD.
  - HOLD, freeze = 0: drive the latched select and flushes for exactly one cycle; return to RUN. Live inputs are ignored that cycle.
- pending = (state == HOLD).
- Statistics:
  - br_total increments once per ex_branch accepted (RUN with freeze = 0, or at capture into HOLD).
  - br_taken increments when that branch also evaluates taken.
  - Counts are not repeated at replay.
  - Both counters saturate at all-ones.

## Timing
- Reset values: state RUN, decision_output 000, flushes 0, pending 0, counters 0.
- Reset mid-HOLD discards the captured redirect.
- RUN latency: 0 cycles; decision_output is valid in the same cycle the inputs are valid, so the PC loads the target at the next edge.
- Replay latency: 1 cycle after freeze falls, the latched select appears in the first cycle with freeze = 0.
- Flush pulses last exactly one cycle per redirect; they are never asserted while freeze = 1.
- Outputs in HOLD (other than the replay cycle) are registered; outputs in RUN are combinational.

## Structure
- A shared package holds:
  - PC_SEL_* constants (000/001/010/011).
  - The COND_* code constants.
  - The RUN/HOLD state enum.
- One sub-module, branch_cond_eval: combinational, ex_cond + ex_flags -> taken.
- The FSM, capture registers and counters stay in pc_decision_unit.

## Test plan
- Reset, then ex_branch = 1, ex_cond = 0010, ex_flags = 0100 (Z = 1), freeze = 0 -> decision_output = 001, flush_ifid = 1, flush_idex = 0 (DELAY_SLOT = 1); br_total = 1, br_taken = 1.
- ex_branch = 1, ex_cond = 0100, flags N = 1, V = 1, with id_jump = 1 -> branch not taken, so decision_output = 010; flush_ifid = 0 with DELAY_SLOT = 1, 1 with DELAY_SLOT = 0.
- ex_jr = 1 and id_jump = 1 together -> 011; with DELAY_SLOT = 0, flush_ifid = flush_idex = 1.
- freeze = 1 while ex_jr = 1 for 3 cycles, with a new id_jump during HOLD -> pending = 1 and output 000 for 3 cycles; first cycle after freeze drops: 011 for one cycle, then RUN; the id_jump is ignored.
- Preload the counters to all-ones (CNT_W = 4, 15 taken branches), then one more taken branch -> both counters stay at 1111.
- reset asserted during HOLD -> next cycle state RUN, pending = 0, decision_output = 000 after freeze drops.
